// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS controller FSM with unified-memory handshake,
// wait-state timeout, optional extended ISA and a retired-instruction counter.
module mc_control #(
  parameter bit          EXT_ISA = 1'b1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       fuc,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             IorD,
  output logic             ir_write,
  output logic             pc_write,
  output logic [2:0]       NPCsle,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [2:0]       ALUOp,
  output logic             ALUSrcB,
  output logic             Extsle,
  output logic [1:0]       exstyle,
  output logic [1:0]       MemData,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             bus_err,
  output logic             halted,
  output logic [2:0]       state
);

  localparam int unsigned WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_ORI, C_LUI, C_ADDIU,
    C_LW, C_SW, C_BEQ, C_J, C_JR, C_JAL, C_ILL
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, dec;
  logic [WCW-1:0]   wait_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q, bus_err_q;
  logic             tmo_hit, tmo_err, retire;

  // Instruction class from the raw opcode/function fields.
  function automatic cls_e decode(input logic [5:0] o, input logic [5:0] f);
    cls_e c;
    c = C_ILL;
    case (o)
      6'b000000: begin
        case (f)
          6'b100000, 6'b100001: c = C_ADD;
          6'b100010, 6'b100011: c = C_SUB;
          6'b100100:            c = EXT_ISA ? C_AND : C_ILL;
          6'b100101:            c = EXT_ISA ? C_OR  : C_ILL;
          6'b101010:            c = EXT_ISA ? C_SLT : C_ILL;
          6'b001000:            c = C_JR;
          default:              c = C_ILL;
        endcase
      end
      6'b000010: c = C_J;
      6'b000011: c = C_JAL;
      6'b000100: c = C_BEQ;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b001101: c = C_ORI;
      6'b001111: c = C_LUI;
      6'b001001: c = EXT_ISA ? C_ADDIU : C_ILL;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  // Final request cycle without ready; ready in the same cycle wins.
  assign tmo_hit = (TIMEOUT != 0) && (wait_q == WCW'(TIMEOUT - 1)) && !mem_ready;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    IorD       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    NPCsle     = 3'b000;
    RegWrite   = 1'b0;
    RegDst     = 2'b00;
    ALUOp      = 3'b000;
    ALUSrcB    = 1'b0;
    Extsle     = 1'b0;
    exstyle    = 2'b00;
    MemData    = 2'b00;
    instr_done = 1'b0;
    halted     = 1'b0;
    tmo_err    = 1'b0;
    retire     = 1'b0;
    dec        = decode(op, fuc);
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (tmo_hit) begin
            tmo_err = 1'b1;
            state_d = S_ERR;
          end
        end
        S_DECODE: begin
          case (dec)
            C_ILL: state_d = S_ERR;
            C_J: begin
              pc_write = 1'b1;
              NPCsle   = 3'b001;
              retire   = 1'b1;
            end
            C_JR: begin
              pc_write = 1'b1;
              NPCsle   = 3'b010;
              retire   = 1'b1;
            end
            C_JAL: begin
              pc_write = 1'b1;
              NPCsle   = 3'b001;
              RegWrite = 1'b1;
              RegDst   = 2'b10;
              MemData  = 2'b10;
              retire   = 1'b1;
            end
            default: state_d = S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls_q)
            C_BEQ: begin
              pc_write = zero;
              NPCsle   = 3'b011;
              retire   = 1'b1;
            end
            C_LW, C_SW: state_d = S_MEM;
            default:    state_d = S_WB;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          mem_we  = (cls_q == C_SW);
          if (mem_ready) begin
            if (cls_q == C_SW) retire = 1'b1;
            else state_d = S_WB;
          end else if (tmo_hit) begin
            tmo_err = 1'b1;
            state_d = S_ERR;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = (cls_q inside {C_ADD, C_SUB, C_AND, C_OR, C_SLT}) ? 2'b01 : 2'b00;
          MemData  = (cls_q == C_LW) ? 2'b01 : 2'b00;
          retire   = 1'b1;
        end
        S_ERR:   halted = 1'b1;
        default: state_d = S_ERR;
      endcase

      // ALU and immediate-extension controls, held through write-back.
      if (state_q == S_EXEC || state_q == S_WB) begin
        case (cls_q)
          C_SUB, C_BEQ: ALUOp = 3'b001;
          C_AND:        ALUOp = 3'b011;
          C_OR, C_ORI:  ALUOp = 3'b010;
          C_SLT:        ALUOp = 3'b100;
          default:      ALUOp = 3'b000;
        endcase
        if (cls_q inside {C_ORI, C_LUI, C_ADDIU, C_LW, C_SW}) begin
          ALUSrcB = 1'b1;
          Extsle  = 1'b1;
        end
        if (cls_q == C_ORI)      exstyle = 2'b01;
        else if (cls_q == C_LUI) exstyle = 2'b10;
      end

      if (retire) begin
        state_d    = S_FETCH;
        instr_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ILL;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)       wait_q <= '0;
      else if (mem_req && !mem_ready) wait_q <= wait_q + 1'b1;
      if (state_q == S_DECODE) cls_q <= dec;
      if (instr_done) retired_q <= retired_q + 1'b1;
      if (state_q == S_DECODE && dec == C_ILL) illegal_q <= 1'b1;
      if (tmo_err) bus_err_q <= 1'b1;
    end
  end

  // Everything reads zero while reset is held, even before the clock edge.
  assign retired = reset ? '0 : retired_q;
  assign illegal = illegal_q & ~reset;
  assign bus_err = bus_err_q & ~reset;
  assign state   = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expected control vectors are
// queued with their stimulus and compared as the FSM steps through them.
module tb_mc_control;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_R = 3'd5;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_ORI = 6'b001101,
                         OP_LUI = 6'b001111, OP_ADDIU = 6'b001001;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, iord, irw, pcw;
    logic [2:0] npc;
    logic       rw;
    logic [1:0] rd;
    logic [2:0] alu;
    logic       srcb, ext;
    logic [1:0] exs, md;
    logic       done, halt;
  } ctl_t;

  typedef struct packed {
    logic       rdy;
    logic [5:0] op, fuc;
    logic       zero;
  } stim_t;

  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = '0, fuc = '0;

  logic mem_req, mem_we, IorD, ir_write, pc_write, RegWrite, ALUSrcB, Extsle, instr_done;
  logic illegal, bus_err, halted;
  logic [2:0] NPCsle, ALUOp, state;
  logic [1:0] RegDst, exstyle, MemData;
  logic [31:0] retired;

  logic mem_req2, mem_we2, IorD2, ir_write2, pc_write2, RegWrite2, ALUSrcB2, Extsle2, instr_done2;
  logic illegal2, bus_err2, halted2;
  logic [2:0] NPCsle2, ALUOp2, state2;
  logic [1:0] RegDst2, exstyle2, MemData2;
  logic [1:0] retired2;

  ctl_t act, act2;
  ctl_t exp_q[$];
  stim_t stim_q[$];
  int errors = 0, checks = 0, exp_ret = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .fuc(fuc), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .ir_write(ir_write), .pc_write(pc_write),
    .NPCsle(NPCsle), .RegWrite(RegWrite), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .Extsle(Extsle), .exstyle(exstyle), .MemData(MemData), .instr_done(instr_done),
    .retired(retired), .illegal(illegal), .bus_err(bus_err), .halted(halted), .state(state)
  );

  mc_control #(.EXT_ISA(1'b0), .TIMEOUT(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .op(op), .fuc(fuc), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req2), .mem_we(mem_we2), .IorD(IorD2), .ir_write(ir_write2), .pc_write(pc_write2),
    .NPCsle(NPCsle2), .RegWrite(RegWrite2), .RegDst(RegDst2), .ALUOp(ALUOp2), .ALUSrcB(ALUSrcB2),
    .Extsle(Extsle2), .exstyle(exstyle2), .MemData(MemData2), .instr_done(instr_done2),
    .retired(retired2), .illegal(illegal2), .bus_err(bus_err2), .halted(halted2), .state(state2)
  );

  assign act  = {state, mem_req, mem_we, IorD, ir_write, pc_write, NPCsle, RegWrite, RegDst,
                 ALUOp, ALUSrcB, Extsle, exstyle, MemData, instr_done, halted};
  assign act2 = {state2, mem_req2, mem_we2, IorD2, ir_write2, pc_write2, NPCsle2, RegWrite2, RegDst2,
                 ALUOp2, ALUSrcB2, Extsle2, exstyle2, MemData2, instr_done2, halted2};

  function automatic ctl_t blank(input logic [2:0] s);
    ctl_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic void push(input ctl_t e, input logic rdy, input logic [5:0] o,
                               input logic [5:0] f, input logic z);
    stim_t s;
    s.rdy = rdy; s.op = o; s.fuc = f; s.zero = z;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  // Expected per-cycle controls for one instruction with fw fetch / mw memory wait cycles.
  function automatic void push_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                                     input int fw, input int mw);
    ctl_t e, x;
    logic rt;
    rt = (o == OP_R);
    for (int i = 0; i < fw; i++) begin
      e = blank(S_F); e.req = 1'b1; push(e, 1'b0, o, f, z);
    end
    e = blank(S_F); e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; push(e, 1'b1, o, f, z);
    e = blank(S_D);
    if (o == OP_J || o == OP_JAL || (rt && f == 6'b001000)) begin
      e.pcw = 1'b1; e.done = 1'b1; e.npc = rt ? 3'b010 : 3'b001;
      if (o == OP_JAL) begin e.rw = 1'b1; e.rd = 2'b10; e.md = 2'b10; end
      push(e, 1'b0, o, f, z); exp_ret++;
      return;
    end
    push(e, 1'b0, o, f, z);
    x = blank(S_E);
    case (o)
      OP_R: begin
        case (f)
          6'b100010: x.alu = 3'b001;
          6'b100100: x.alu = 3'b011;
          6'b100101: x.alu = 3'b010;
          6'b101010: x.alu = 3'b100;
          default:   x.alu = 3'b000;
        endcase
      end
      OP_ORI:  begin x.alu = 3'b010; x.srcb = 1'b1; x.ext = 1'b1; x.exs = 2'b01; end
      OP_LUI:  begin x.srcb = 1'b1; x.ext = 1'b1; x.exs = 2'b10; end
      OP_BEQ:  x.alu = 3'b001;
      default: begin x.srcb = 1'b1; x.ext = 1'b1; end
    endcase
    if (o == OP_BEQ) begin
      x.pcw = z; x.npc = 3'b011; x.done = 1'b1;
      push(x, 1'b0, o, f, z); exp_ret++;
      return;
    end
    push(x, 1'b0, o, f, z);
    if (o == OP_LW || o == OP_SW) begin
      for (int i = 0; i <= mw; i++) begin
        e = blank(S_M); e.req = 1'b1; e.iord = 1'b1; e.we = (o == OP_SW);
        e.done = (i == mw) && (o == OP_SW);
        push(e, i == mw, o, f, z);
      end
      if (o == OP_SW) begin exp_ret++; return; end
    end
    e = x; e.st = S_W; e.rw = 1'b1; e.done = 1'b1;
    e.rd = rt ? 2'b01 : 2'b00;
    e.md = (o == OP_LW) ? 2'b01 : 2'b00;
    push(e, 1'b0, o, f, z); exp_ret++;
  endfunction

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; exp_ret = 0;
  endtask

  task automatic test_reset();
    ctl_t e;
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({act, retired, illegal, bus_err, act2} !== '0)
      begin errors++; $display("FAIL reset_idle got=%h/%h want=0", act, act2); end
    do_reset();
    op = OP_LW; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({state, mem_req, IorD} !== 5'b01111)
      begin errors++; $display("FAIL reset_reach_mem got=%b want=01111", {state, mem_req, IorD}); end
    reset = 1'b1; #1;
    checks++;
    if ({act, retired} !== '0)
      begin errors++; $display("FAIL reset_mid got=%h ret=%0d want=0", act, retired); end
    @(negedge clk); reset = 1'b0; #1;
    e = blank(S_F); e.req = 1'b1;
    checks++;
    if (act !== e || retired !== 32'd0)
      begin errors++; $display("FAIL reset_exit got=%h ret=%0d want=%h ret=0", act, retired, e); end
  endtask

  task automatic test_add();
    stim_t s; ctl_t e; int cyc = 0;
    do_reset();
    push_instr(OP_R, 6'b100000, 1'b0, 0, 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); mem_ready = s.rdy; op = s.op; fuc = s.fuc; zero = s.zero;
      #1; e = exp_q.pop_front(); checks++; cyc++;
      if (act !== e) begin errors++; $display("FAIL add cyc=%0d got=%h want=%h", cyc, act, e); end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1; checks++;
    if (retired !== 32'(exp_ret)) begin errors++; $display("FAIL add_retired got=%0d want=%0d", retired, exp_ret); end
  endtask

  task automatic test_lw_wait();
    stim_t s; ctl_t e; int cyc = 0;
    do_reset();
    push_instr(OP_LW, 6'b000000, 1'b0, 0, 3);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); mem_ready = s.rdy; op = s.op; fuc = s.fuc; zero = s.zero;
      #1; e = exp_q.pop_front(); checks++; cyc++;
      if (act !== e) begin errors++; $display("FAIL lw_wait cyc=%0d got=%h want=%h", cyc, act, e); end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1; checks++;
    if (cyc != 8 || retired !== 32'd1) begin errors++; $display("FAIL lw_len cyc=%0d ret=%0d want 8/1", cyc, retired); end
  endtask

  task automatic test_beq();
    stim_t s; ctl_t e; int cyc = 0;
    do_reset();
    push_instr(OP_BEQ, 6'b000000, 1'b0, 0, 0);
    push_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); mem_ready = s.rdy; op = s.op; fuc = s.fuc; zero = s.zero;
      #1; e = exp_q.pop_front(); checks++; cyc++;
      if (act !== e) begin errors++; $display("FAIL beq cyc=%0d got=%h want=%h", cyc, act, e); end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1; checks++;
    if (retired !== 32'(exp_ret)) begin errors++; $display("FAIL beq_retired got=%0d want=%0d", retired, exp_ret); end
  endtask

  task automatic test_jumps();
    stim_t s; ctl_t e; int cyc = 0;
    do_reset();
    push_instr(OP_JAL, 6'b000000, 1'b0, 0, 0);
    push_instr(OP_J, 6'b000000, 1'b0, 1, 0);
    push_instr(OP_R, 6'b001000, 1'b0, 0, 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); mem_ready = s.rdy; op = s.op; fuc = s.fuc; zero = s.zero;
      #1; e = exp_q.pop_front(); checks++; cyc++;
      if (act !== e) begin errors++; $display("FAIL jumps cyc=%0d got=%h want=%h", cyc, act, e); end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1; checks++;
    if (retired !== 32'(exp_ret)) begin errors++; $display("FAIL jumps_retired got=%0d want=%0d", retired, exp_ret); end
  endtask

  task automatic test_back_to_back();
    stim_t s; ctl_t e; int cyc = 0;
    do_reset();
    push_instr(OP_ORI, 6'b000000, 1'b0, 1, 0);
    push_instr(OP_LUI, 6'b000000, 1'b0, 0, 0);
    push_instr(OP_ADDIU, 6'b000000, 1'b0, 2, 0);
    push_instr(OP_R, 6'b100100, 1'b0, 0, 0);
    push_instr(OP_R, 6'b100101, 1'b0, 0, 0);
    push_instr(OP_R, 6'b101010, 1'b0, 0, 0);
    push_instr(OP_R, 6'b100010, 1'b0, 0, 0);
    push_instr(OP_SW, 6'b000000, 1'b0, 1, 2);
    push_instr(OP_LW, 6'b000000, 1'b0, 0, 0);
    push_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); mem_ready = s.rdy; op = s.op; fuc = s.fuc; zero = s.zero;
      #1; e = exp_q.pop_front(); checks++; cyc++;
      if (act !== e) begin errors++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, act, e); end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1; checks++;
    if (retired !== 32'(exp_ret)) begin errors++; $display("FAIL b2b_retired got=%0d want=%0d", retired, exp_ret); end
  endtask

  task automatic test_timeout();
    stim_t s; ctl_t e; int cyc = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin e = blank(S_F); e.req = 1'b1; push(e, 1'b0, OP_J, 6'd0, 1'b0); end
    e = blank(S_R); e.halt = 1'b1;
    push(e, 1'b0, OP_J, 6'd0, 1'b0);
    push(e, 1'b1, OP_J, 6'd0, 1'b0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); mem_ready = s.rdy; op = s.op; fuc = s.fuc; zero = s.zero;
      #1; e = exp_q.pop_front(); checks++; cyc++;
      if (act2 !== e) begin errors++; $display("FAIL timeout cyc=%0d got=%h want=%h", cyc, act2, e); end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1; checks++;
    if ({bus_err2, illegal2} !== 2'b10) begin errors++; $display("FAIL timeout_flags got=%b want=10", {bus_err2, illegal2}); end
    do_reset(); #1;
    e = blank(S_F); e.req = 1'b1; checks++;
    if (act2 !== e || bus_err2 !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%h err=%b want=%h err=0", act2, bus_err2, e); end
  endtask

  task automatic test_illegal();
    stim_t s; ctl_t e; int cyc = 0;
    do_reset();
    e = blank(S_F); e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    push(e, 1'b1, OP_ADDIU, 6'd0, 1'b0);
    push(blank(S_D), 1'b0, OP_ADDIU, 6'd0, 1'b0);
    e = blank(S_R); e.halt = 1'b1;
    push(e, 1'b0, OP_ADDIU, 6'd0, 1'b0);
    push(e, 1'b1, OP_ADDIU, 6'd0, 1'b0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); mem_ready = s.rdy; op = s.op; fuc = s.fuc; zero = s.zero;
      #1; e = exp_q.pop_front(); checks++; cyc++;
      if (act2 !== e) begin errors++; $display("FAIL illegal cyc=%0d got=%h want=%h", cyc, act2, e); end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1; checks++;
    if ({illegal2, bus_err2, retired2} !== 4'b1000)
      begin errors++; $display("FAIL illegal_flags got=%b want=1000", {illegal2, bus_err2, retired2}); end
  endtask

  task automatic test_wrap();
    stim_t s; ctl_t e; int cyc = 0;
    do_reset();
    for (int k = 0; k < 3; k++) push_instr(OP_J, 6'd0, 1'b0, 3, 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); mem_ready = s.rdy; op = s.op; fuc = s.fuc; zero = s.zero;
      #1; e = exp_q.pop_front(); checks++; cyc++;
      if (act2 !== e) begin errors++; $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, act2, e); end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1; checks++;
    if (retired2 !== 2'd3) begin errors++; $display("FAIL wrap_three got=%0d want=3", retired2); end
    push_instr(OP_J, 6'd0, 1'b0, 3, 0);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); mem_ready = s.rdy; op = s.op; fuc = s.fuc; zero = s.zero;
      #1; e = exp_q.pop_front(); checks++; cyc++;
      if (act2 !== e) begin errors++; $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, act2, e); end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1; checks++;
    if (retired2 !== 2'(exp_ret)) begin errors++; $display("FAIL wrap_zero got=%0d want=%0d", retired2, 2'(exp_ret)); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_jumps();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
